pwm_ramp_ctrl: RTL
==================

# pwm_ramp_ctrl

Configuration sequencer for the 16-bit `pwm` generator. It accepts a configuration from a host over a valid/ready handshake and applies it to the generator. It then ramps the generator's compare value from its current value to a target in fixed steps, one step every (div+1) PWM periods. It tracks PWM period boundaries with an internal period counter that is phase-locked to the generator through the generator reset it drives.

## Interface
Parameters:
- `DIV_W`, 8: width of the periods-per-step divider.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_valid`  in  1  host presents a configuration.
- `cfg_ready`  out  1  controller accepts a configuration this cycle.
- `cfg_top`  in  16  PWM top value; 0 is clamped to 1.
- `cfg_target`  in  16  final compare value.
- `cfg_step`  in  16  compare increment per step; 0 means jump directly.
- `cfg_div`  in  DIV_W  step every cfg_div+1 periods.
- `cfg_mode`  in  1  0 = sawtooth, 1 = triangle.
- `cfg_pol`  in  1  output polarity, passed through to the generator.
- `pwm_top`  out  16  drives generator `top`.
- `pwm_comp`  out  16  drives generator `comp`.
- `pwm_mode`  out  1  drives generator `mode`.
- `pwm_pol`  out  1  drives generator `pol`.
- `pwm_rst`  out  1  drives generator `rst`.
- `period_end`  out  1  one-cycle pulse on the last cycle of each PWM period.
- `busy`  out  1  high in LOAD or RAMP.
- `done`  out  1  one-cycle pulse when the compare value reaches the target.

## Operation
- States: IDLE, LOAD, RAMP, HOLD.
- Reset values:
  - State is IDLE.
  - `pwm_rst` = 1. `pwm_top` = 1. `pwm_comp` = 0. `pwm_mode` = 0. `pwm_pol` = 0.
  - `cfg_ready` = 1. `busy` = 0. `done` = 0. `period_end` = 0.
  - Period counter is 0. Step divider counter is 0.
- IDLE: `pwm_rst` held at 1. `cfg_ready` = 1.
- HOLD: the generator runs with `pwm_rst` = 0. `cfg_ready` = 1.
- Handshake: a transfer occurs when `cfg_valid` and `cfg_ready` are both high on a clock edge. On a transfer:
  - top (clamped), target, step, div, mode and pol are registered.
  - `pwm_top`, `pwm_mode` and `pwm_pol` update.
  - `pwm_comp` keeps its current value. It is 0 after reset.
  - The next state is LOAD.
- `cfg_ready` = 0 in LOAD and RAMP. Configurations are not accepted mid-ramp.
- LOAD lasts one cycle, with `pwm_rst` = 1. The period counter and divider clear to 0. The next state is RAMP.
- RAMP/HOLD: `pwm_rst` = 0. The period counter counts 0..P-1 and wraps.
  - P = top+1 when mode = 0.
  - P = 2·top when mode = 1.
  - The counter is 17 bits wide.
- `period_end` = 1 when the period counter equals P-1 and the state is RAMP or HOLD.
- Divider: increments on each `period_end`. When it equals div, it clears and a step fires.
- Step arithmetic, with d = |target − comp| computed unsigned with 17-bit intermediates:
  - If step = 0 or d ≤ step, then comp ← target.
  - Otherwise comp ← comp ± step, moving toward target.
  - The result never overshoots and never wraps.
- Entering RAMP with comp = target: go to HOLD on the first cycle of RAMP, with no period wait.
- Reaching target: the step that makes comp = target moves the state to HOLD, and `done` pulses in the cycle the state is HOLD for the first time.
- Mid-operation `rst` returns all outputs to their reset values on the next edge.
- `cfg_valid` held high in HOLD reloads immediately; the ramp restarts from the current comp.

## Timing
- Transfer edge → LOAD the next cycle. `pwm_rst` is high for exactly one cycle. The period counter and generator state are both 0 in the first RAMP cycle.
- `pwm_comp` changes on the edge after the `period_end` cycle that completes the divider count, so the change lands on the period boundary.
- Worst-case ramp latency = ceil(d/step)·(div+1)·P cycles after the first RAMP cycle.
- `done` follows the final comp update by one cycle.

## Configuration
- `PWM_RAMP_IRQ_EN`: when defined, the block adds two ports:
  - `irq_clr` (in, 1): clears the flag.
  - `irq` (out, 1): sticky flag.
- `irq` is set on `done`, cleared by `irq_clr`, and reset to 0 by `rst`.
- If `done` and `irq_clr` occur in the same cycle, set wins.
- When the macro is undefined, the ports and the flag are absent and all other behaviour is identical.

## Test plan
- Reset, then configure top=9, mode=0, target=5, step=0, div=0:
  - `pwm_rst` is high for one cycle.
  - `period_end` pulses every 10 cycles.
  - comp jumps 0→5 at the first period end.
  - `done` pulses once and the state is HOLD.
- top=4, mode=1, target=7, step=3, div=1, starting from comp=0:
  - comp goes 3, 6, 7, with updates every 16 cycles (2 periods of P=8).
  - `done` pulses after the comp=7 update.
- Ramp down:
  - From HOLD at comp=7, configure target=0, step=5.
  - comp goes 2, then 0, with no wrap.
- Back-to-back configuration, `cfg_valid` held high:
  - `cfg_ready` drops during LOAD/RAMP.
  - A second transfer happens only once HOLD is reached.
  - top=0 is clamped so that P=2.
- Reset mid-RAMP:
  - Assert `rst` during the comp 3→6 ramp.
  - Next cycle: IDLE, `pwm_rst` = 1, `pwm_comp` = 0, `busy` = 0.
- With `PWM_RAMP_IRQ_EN` defined:
  - `irq` sets on `done` and stays set until `irq_clr`.
  - When `done` and `irq_clr` occur in the same cycle, `irq` remains 1.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Configuration sequencer for the 16-bit pwm generator: loads a config, then ramps compare to target.
// Optional sticky completion flag (irq/irq_clr) when PWM_RAMP_IRQ_EN is defined.
module pwm_ramp_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [15:0]      cfg_top,
    input  logic [15:0]      cfg_target,
    input  logic [15:0]      cfg_step,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_mode,
    input  logic             cfg_pol,
`ifdef PWM_RAMP_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [15:0]      pwm_top,
    output logic [15:0]      pwm_comp,
    output logic             pwm_mode,
    output logic             pwm_pol,
    output logic             pwm_rst,
    output logic             period_end,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_t;

    state_t            state, state_nxt;
    logic [15:0]       target_r, step_r;
    logic [DIV_W-1:0]  div_r;
    logic [16:0]       pcnt, plast;
    logic [DIV_W-1:0]  dcnt;
    logic [15:0]       comp_nxt;
    logic              step_fire;
    logic              xfer;

    // One step toward tgt; distance kept in 17 bits so it never overshoots or wraps.
    function automatic logic [15:0] ramp_step(input logic [15:0] cur, input logic [15:0] tgt,
                                              input logic [15:0] stp);
        logic [16:0] d;
        if (cur > tgt)
            d = {1'b0, cur} - {1'b0, tgt};
        else
            d = {1'b0, tgt} - {1'b0, cur};
        if (stp == 16'd0 || d <= {1'b0, stp})
            return tgt;
        else if (cur > tgt)
            return cur - stp;
        else
            return cur + stp;
    endfunction

    assign xfer = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        pwm_rst    = 1'b0;
        busy       = 1'b0;
        period_end = 1'b0;
        step_fire  = 1'b0;
        plast      = pwm_mode ? ({pwm_top, 1'b0} - 17'd1) : {1'b0, pwm_top};
        comp_nxt   = ramp_step(pwm_comp, target_r, step_r);
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                pwm_rst   = 1'b1;
                if (cfg_valid) state_nxt = LOAD;
            end
            LOAD: begin
                pwm_rst   = 1'b1;
                busy      = 1'b1;
                state_nxt = RAMP;
            end
            RAMP: begin
                busy       = 1'b1;
                period_end = (pcnt == plast);
                if (pwm_comp == target_r) begin
                    state_nxt = HOLD;
                end else if (period_end && dcnt == div_r) begin
                    step_fire = 1'b1;
                    if (comp_nxt == target_r) state_nxt = HOLD;
                end
            end
            HOLD: begin
                cfg_ready  = 1'b1;
                period_end = (pcnt == plast);
                if (cfg_valid) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pwm_top  <= 16'd1;
            pwm_comp <= 16'd0;
            pwm_mode <= 1'b0;
            pwm_pol  <= 1'b0;
            pcnt     <= '0;
            dcnt     <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == HOLD) && (state != HOLD);
            if (xfer) begin
                pwm_top  <= (cfg_top == 16'd0) ? 16'd1 : cfg_top;
                pwm_mode <= cfg_mode;
                pwm_pol  <= cfg_pol;
            end
            if (step_fire) pwm_comp <= comp_nxt;
            // Counters run only while the generator runs, so both start at 0 together.
            if (state == RAMP || state == HOLD) begin
                pcnt <= (pcnt == plast) ? 17'd0 : pcnt + 17'd1;
                if (period_end) dcnt <= (dcnt == div_r) ? '0 : dcnt + 1'b1;
            end else begin
                pcnt <= '0;
                dcnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            target_r <= cfg_target;
            step_r   <= cfg_step;
            div_r    <= cfg_div;
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else if (done)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule
